// File: rtl/gtt_pkg.sv
// Shared types for the gate truth-table engine: gate function encoding,
// sweep FSM states and a table-width helper.
package gtt_pkg;

    // Run-time gate function selected by the 3-bit mode input
    typedef enum logic [2:0] {
        GM_AND  = 3'b000,
        GM_OR   = 3'b001,
        GM_NAND = 3'b010,
        GM_NOR  = 3'b011,
        GM_XOR  = 3'b100,   // odd parity over all inputs
        GM_XNOR = 3'b101,
        GM_BUF  = 3'b110,   // passes in[0]
        GM_NOT  = 3'b111    // inverts in[0]
    } gate_mode_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } gtt_state_e;

    // Largest supported gate input count (table of 64 bits)
    localparam int unsigned N_IN_MAX = 6;

    // Number of truth-table entries for an n-input gate
    function automatic int unsigned table_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/nin_gate.sv
// nin_gate: purely combinational N-input gate with a run-time function select.
// Standalone so other gate benches can reuse it directly.
module nin_gate
    import gtt_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] in_i,
    input  gate_mode_e      mode_i,
    output logic            y_o
);

    // Reduction over all inputs; BUF/NOT look only at the LSB input
    always_comb begin
        y_o = 1'b0;
        unique case (mode_i)
            GM_AND:  y_o =  (&in_i);
            GM_OR:   y_o =  (|in_i);
            GM_NAND: y_o = ~(&in_i);
            GM_NOR:  y_o = ~(|in_i);
            GM_XOR:  y_o =  (^in_i);
            GM_XNOR: y_o = ~(^in_i);
            GM_BUF:  y_o =  in_i[0];
            GM_NOT:  y_o = ~in_i[0];
            default: y_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_truth_table_engine.sv
// gate_truth_table_engine: on start, sweeps every input vector of an N_IN-input
// gate through nin_gate under a latched mode and captures the truth table
// (bit i = f(vector i)).
// Optional feature macro GTT_CHECK_EN adds an expected-table input and a
// mismatch flag that is evaluated as the sweep completes.
module gate_truth_table_engine
    import gtt_pkg::*;
#(
    parameter  int N_IN = 2,
    localparam int TW   = 1 << N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mode,
    output logic            busy,
    output logic            done,
    output logic [N_IN-1:0] vec,
    output logic            y_live,
`ifdef GTT_CHECK_EN
    input  logic [TW-1:0]   exp_table,
    output logic            mismatch,
`endif
    output logic [TW-1:0]   table_out
);

    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

    gtt_state_e        state_q;
    gate_mode_e        mode_q;
    logic [N_IN-1:0]   vec_q;
    logic              busy_q;
    logic              done_q;
    logic [TW-1:0]     table_q;
    logic [TW-1:0]     table_d;
    logic              start_acc;
    logic              gate_y;

`ifdef GTT_CHECK_EN
    logic [TW-1:0]     exp_q;
    logic              mismatch_q;
`endif

    // A start is honoured only when not sweeping; reset overrides it
    assign start_acc = start && !rst && (state_q == ST_IDLE || state_q == ST_DONE);

    nin_gate #(
        .N_IN (N_IN)
    ) u_gate (
        .in_i   (vec_q),
        .mode_i (mode_q),
        .y_o    (gate_y)
    );

    // Table with the current vector's result inserted; the final value of this
    // on the last sweep cycle is what the checker compares against
    always_comb begin
        table_d         = table_q;
        table_d[vec_q]  = gate_y;
    end

    // Sequencer: IDLE/DONE wait for start, SWEEP walks vec 0..TW-1 once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= GM_AND;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= '0;
`ifdef GTT_CHECK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_acc) begin
                        state_q    <= ST_SWEEP;
                        mode_q     <= gate_mode_e'(mode);
                        vec_q      <= '0;
                        table_q    <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
`ifdef GTT_CHECK_EN
                        mismatch_q <= 1'b0;
`endif
                    end
                end
                ST_SWEEP: begin
                    table_q <= table_d;
                    if (vec_q == VEC_LAST) begin
                        state_q    <= ST_DONE;
                        vec_q      <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
`ifdef GTT_CHECK_EN
                        mismatch_q <= (table_d != exp_q);
`endif
                    end else begin
                        vec_q <= vec_q + VEC_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GTT_CHECK_EN
    // Expected table is plain data: captured on accepted start, never reset
    always_ff @(posedge clk) begin
        if (start_acc) begin
            exp_q <= exp_table;
        end
    end

    assign mismatch = mismatch_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign vec       = vec_q;
    assign y_live    = gate_y;
    assign table_out = table_q;

endmodule
